execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs E_stat in 2, E_icode in 4, E_ifun in 4: the registered E-stage instruction.
REQ-004 SHALL have inputs E_valC, E_valA, E_valB in 64 (signed), E_dstE, E_dstM in 4: the registered E-stage operands and destinations.
REQ-005 SHALL have inputs M_bubble in 1 (inject nop into M), m_stat in 2 (memory-stage status), W_stat in 2 (write-back status).
REQ-006 SHALL have combinational outputs e_valE out 64, e_dstE out 4, e_Cnd out 1, for forwarding to decode.
REQ-007 SHALL have registered outputs M_stat 2, M_icode 4, M_Cnd 1, M_valE 64, M_valA 64, M_dstE 4, M_dstM 4.
REQ-008 SHALL have outputs ZF, SF, OF, each out 1: the current condition-code register.

Function
REQ-009 SHALL select aluA as follows: E_valA for icode 2 or 6; E_valC for icode 3, 4 or 5; -8 for icode 8 or A; +8 for icode 9 or B; 0 otherwise.
REQ-010 SHALL select aluB as follows: E_valB for icode 4, 5, 6, 8, 9, A or B; 0 for icode 2 or 3 and otherwise.
REQ-011 SHALL use alufun = E_ifun when icode=6, else ADD; ifun 0 ADD aluB+aluA, 1 SUB aluB-aluA, 2 AND, 3 XOR; all arithmetic is 64-bit two's complement, wrapping and not saturating.
REQ-012 SHALL, for OPq with ifun>3, drive e_valE=0 and update no CC.
REQ-013 SHALL compute new flags as: ZF = (result==0); SF = result[63]; OF for ADD = sign(aluA)==sign(aluB) and sign(result)!=sign(aluA); OF for SUB = sign(aluA)!=sign(aluB) and sign(result)!=sign(aluB); OF=0 for AND/XOR.
REQ-014 SHALL define set_cc = (E_icode==6) and (ifun<=3) and m_stat==AOK and W_stat==AOK.
REQ-015 SHALL load CC on posedge when set_cc=1; M_bubble SHALL NOT block this load.
REQ-016 SHALL compute e_Cnd from the current (pre-update) CC for ifun 0..6: always, le (SF^OF)|ZF, l SF^OF, e ZF, ne !ZF, ge !(SF^OF), g !(SF^OF)&!ZF; ifun>6 gives 0.
REQ-017 SHALL drive e_dstE = 4'hF when E_icode==2 and e_Cnd==0, else E_dstE.
REQ-018 SHALL, on posedge with M_bubble=0, load M_stat=E_stat, M_icode=E_icode, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM; latency E->M is 1 cycle.
REQ-019 SHALL, on posedge with M_bubble=1, load M_icode=1 (nop), M_stat=0 (AOK), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF.
REQ-020 SHALL use the stat encoding 0 AOK, 1 HLT, 2 ADR, 3 INS.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force all M_* outputs to the bubble values of REQ-019, regardless of clk.
REQ-022 SHALL, while rst_n=0, force ZF=1, SF=0, OF=0.
REQ-023 SHALL give rst_n priority over M_bubble and set_cc; a mid-operation reset discards the in-flight instruction and any pending CC update.
REQ-024 SHALL resume normal capture at the first posedge after rst_n deasserts.

Structure
REQ-025 SHALL hold icode constants, stat codes, alufun codes and RNONE=4'hF in shared package y86_pkg.
REQ-026 SHALL implement the combinational 64-bit ALU and flag generation as sub-module alu.

Verification
REQ-027 Bench SHALL cover: rst_n low mid-stream with M_icode=6 -> same-cycle M_icode=1, M_dstE=F, ZF=1, SF=0, OF=0.
REQ-028 Bench SHALL cover: OPq SUB, valA=5, valB=3 -> e_valE=0xFFFF_FFFF_FFFF_FFFE; next edge SF=1, ZF=0, OF=0.
REQ-029 Bench SHALL cover: OPq ADD, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=0x8000_0000_0000_0000; OF=1, SF=1.
REQ-030 Bench SHALL cover: cmovle (icode 2, ifun 1) with SF=OF=ZF=0, E_dstE=3 -> e_Cnd=0, e_dstE=F, next M_dstE=F.
REQ-031 Bench SHALL cover: pushq with valB=0x100 -> e_valE=0xF8, e_dstE=E_dstE, CC unchanged.
REQ-032 Bench SHALL cover: OPq with M_bubble=1 and m_stat=AOK -> M_icode=1 and CC updated; the same OPq with W_stat=HLT -> CC unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage:
// instruction codes, status codes, ALU functions and the M-stage bundle.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        valE:  64'd0,
        valA:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE
    };

endpackage

// File: rtl/execute_alu.sv
// 64-bit two's-complement ALU with Y86 condition flag generation.
// Unknown function codes yield a zero result with OF clear.
module alu
    import y86_pkg::*;
(
    input  logic [63:0] alu_a_i,
    input  logic [63:0] alu_b_i,
    input  logic [3:0]  fun_i,
    output logic [63:0] result_o,
    output logic        zf_o,
    output logic        sf_o,
    output logic        of_o
);

    logic sa, sb, sr;

    assign sa = alu_a_i[63];
    assign sb = alu_b_i[63];
    assign sr = result_o[63];

    always_comb begin
        result_o = 64'd0;
        of_o     = 1'b0;
        case (fun_i)
            ALU_ADD: begin
                result_o = alu_b_i + alu_a_i;
                of_o     = (sa == sb) && (sr != sa);
            end
            ALU_SUB: begin
                result_o = alu_b_i - alu_a_i;
                of_o     = (sa != sb) && (sr != sb);
            end
            ALU_AND: result_o = alu_b_i & alu_a_i;
            ALU_XOR: result_o = alu_b_i ^ alu_a_i;
            default: result_o = 64'd0;
        endcase
    end

    assign zf_o = (result_o == 64'd0);
    assign sf_o = result_o[63];

endmodule

// File: rtl/execute.sv
// Y86-64 pipeline execute stage: operand select, ALU, condition codes,
// branch/cmov condition and the E->M pipeline register.
module execute
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic        M_bubble,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [1:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);

    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        new_zf, new_sf, new_of;
    logic        set_cc;
    logic        zf_q, sf_q, of_q;
    m_reg_t      m_d, m_q;

    always_comb begin
        alu_a = 64'd0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:           alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ,
            I_MRMOVQ:                  alu_a = E_valC;
            I_CALL, I_PUSHQ:           alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:             alu_a = 64'd8;
            default:                   alu_a = 64'd0;
        endcase
    end

    always_comb begin
        alu_b = 64'd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET,
            I_PUSHQ, I_POPQ:           alu_b = E_valB;
            default:                   alu_b = 64'd0;
        endcase
    end

    assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    alu u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .fun_i    (alu_fun),
        .result_o (e_valE),
        .zf_o     (new_zf),
        .sf_o     (new_sf),
        .of_o     (new_of)
    );

    // CC only latches for defined OPq functions while no later stage faulted
    assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR)
                 && (m_stat == S_AOK) && (W_stat == S_AOK);

    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            4'd0:    e_Cnd = 1'b1;
            4'd1:    e_Cnd = (sf_q ^ of_q) | zf_q;
            4'd2:    e_Cnd = sf_q ^ of_q;
            4'd3:    e_Cnd = zf_q;
            4'd4:    e_Cnd = !zf_q;
            4'd5:    e_Cnd = !(sf_q ^ of_q);
            4'd6:    e_Cnd = !(sf_q ^ of_q) && !zf_q;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (set_cc) begin
            zf_q <= new_zf;
            sf_q <= new_sf;
            of_q <= new_of;
        end
    end

    always_comb begin
        m_d = M_BUBBLE;
        if (!M_bubble) begin
            m_d.stat  = E_stat;
            m_d.icode = E_icode;
            m_d.cnd   = e_Cnd;
            m_d.valE  = e_valE;
            m_d.valA  = E_valA;
            m_d.dstE  = e_dstE;
            m_d.dstM  = E_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_q <= M_BUBBLE;
        else        m_q <= m_d;
    end

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_Cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;

    assign ZF = zf_q;
    assign SF = sf_q;
    assign OF = of_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the Y86-64 execute stage.
// Each task drives a scenario and checks hand-computed values inline.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM;
    logic        M_bubble;
    logic [1:0]  m_stat, W_stat;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        ZF, SF, OF;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .M_bubble (M_bubble),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .M_stat   (M_stat),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .ZF       (ZF),
        .SF       (SF),
        .OF       (OF)
    );

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [3:0] de,
                         input logic [3:0] dm);
        E_icode = ic;
        E_ifun  = fn;
        E_valA  = a;
        E_valB  = b;
        E_valC  = c;
        E_dstE  = de;
        E_dstM  = dm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM} !== {2'd0, 4'h1, 1'b0, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL reset_m stat=%0d icode=%h cnd=%b dstE=%h dstM=%h exp 0/1/0/F/F",
                     M_stat, M_icode, M_Cnd, M_dstE, M_dstM);
        end
        checks++;
        if ({M_valE, M_valA} !== 128'd0) begin
            failures++;
            $display("FAIL reset_vals valE=%h valA=%h exp 0", M_valE, M_valA);
        end
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("FAIL reset_cc zso=%b exp 100", {ZF, SF, OF});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(4'h3, 4'h0, 64'h999, 64'h777, 64'h1234, 4'h5, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'h1234) begin
            failures++;
            $display("FAIL irmovq_valE got=%h exp=1234", e_valE);
        end
        tick();
        checks++;
        if ({M_icode, M_valE, M_dstE} !== {4'h3, 64'h1234, 4'h5}) begin
            failures++;
            $display("FAIL irmovq_m icode=%h valE=%h dstE=%h exp 3/1234/5", M_icode, M_valE, M_dstE);
        end
        drive(4'h5, 4'h0, 64'h0, 64'h10, 64'h8, 4'hF, 4'h6);
        tick();
        checks++;
        if ({M_icode, M_valE, M_dstM} !== {4'h5, 64'h18, 4'h6}) begin
            failures++;
            $display("FAIL mrmovq_m icode=%h valE=%h dstM=%h exp 5/18/6", M_icode, M_valE, M_dstM);
        end
        drive(4'h4, 4'h0, 64'hAB, 64'h30, 64'h20, 4'hF, 4'hF);
        tick();
        checks++;
        if ({M_valE, M_valA} !== {64'h50, 64'hAB}) begin
            failures++;
            $display("FAIL rmmovq_m valE=%h valA=%h exp 50/AB", M_valE, M_valA);
        end
        drive(4'h8, 4'h0, 64'h0, 64'h100, 64'h400, 4'h4, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'hF8) begin
            failures++;
            $display("FAIL call_valE got=%h exp=F8", e_valE);
        end
        tick();
        drive(4'h9, 4'h0, 64'h0, 64'hF8, 64'h0, 4'h4, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'h100) begin
            failures++;
            $display("FAIL ret_valE got=%h exp=100", e_valE);
        end
        tick();
        drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'h0) begin
            failures++;
            $display("FAIL add_wrap_valE got=%h exp=0", e_valE);
        end
        tick();
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("FAIL add_wrap_cc zso=%b exp 100", {ZF, SF, OF});
        end
    endtask

    task automatic test_sub();
        drive(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 4'h2, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            failures++;
            $display("FAIL sub_valE got=%h exp=FFFFFFFFFFFFFFFE", e_valE);
        end
        tick();
        checks++;
        if ({ZF, SF, OF} !== 3'b010) begin
            failures++;
            $display("FAIL sub_cc zso=%b exp 010", {ZF, SF, OF});
        end
        checks++;
        if ({M_icode, M_valE} !== {4'h6, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            failures++;
            $display("FAIL sub_m icode=%h valE=%h", M_icode, M_valE);
        end
    endtask

    task automatic test_add_overflow();
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL add_ovf_valE got=%h exp=8000000000000000", e_valE);
        end
        tick();
        checks++;
        if ({ZF, SF, OF} !== 3'b011) begin
            failures++;
            $display("FAIL add_ovf_cc zso=%b exp 011", {ZF, SF, OF});
        end
    endtask

    task automatic test_cmov();
        drive(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2, 4'hF);
        tick();
        checks++;
        if ({ZF, SF, OF} !== 3'b000) begin
            failures++;
            $display("FAIL clr_cc zso=%b exp 000", {ZF, SF, OF});
        end
        drive(4'h2, 4'h1, 64'h42, 64'h0, 64'h0, 4'h3, 4'hF);
        #1;
        checks++;
        if ({e_Cnd, e_dstE, e_valE} !== {1'b0, 4'hF, 64'h42}) begin
            failures++;
            $display("FAIL cmovle_e cnd=%b dstE=%h valE=%h exp 0/F/42", e_Cnd, e_dstE, e_valE);
        end
        tick();
        checks++;
        if ({M_Cnd, M_dstE} !== {1'b0, 4'hF}) begin
            failures++;
            $display("FAIL cmovle_m cnd=%b dstE=%h exp 0/F", M_Cnd, M_dstE);
        end
        drive(4'h2, 4'h6, 64'h42, 64'h0, 64'h0, 4'h3, 4'hF);
        #1;
        checks++;
        if ({e_Cnd, e_dstE} !== {1'b1, 4'h3}) begin
            failures++;
            $display("FAIL cmovg_e cnd=%b dstE=%h exp 1/3", e_Cnd, e_dstE);
        end
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        #1;
        checks++;
        if (e_Cnd !== 1'b0) begin
            failures++;
            $display("FAIL jxx_ifun7 cnd=%b exp 0", e_Cnd);
        end
        tick();
    endtask

    task automatic test_push();
        drive(4'hA, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'hF);
        #1;
        checks++;
        if ({e_valE, e_dstE} !== {64'hF8, 4'h4}) begin
            failures++;
            $display("FAIL push_e valE=%h dstE=%h exp F8/4", e_valE, e_dstE);
        end
        tick();
        checks++;
        if ({ZF, SF, OF, M_valE} !== {3'b000, 64'hF8}) begin
            failures++;
            $display("FAIL push_m zso=%b valE=%h exp 000/F8", {ZF, SF, OF}, M_valE);
        end
    endtask

    task automatic test_bad_ifun();
        E_stat = 2'd3;
        drive(4'h6, 4'h4, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF);
        #1;
        checks++;
        if (e_valE !== 64'h0) begin
            failures++;
            $display("FAIL badfn_valE got=%h exp=0", e_valE);
        end
        tick();
        checks++;
        if ({ZF, SF, OF, M_stat} !== {3'b000, 2'd3}) begin
            failures++;
            $display("FAIL badfn_m zso=%b stat=%0d exp 000/3", {ZF, SF, OF}, M_stat);
        end
        E_stat = 2'd0;
    endtask

    task automatic test_bubble_cc();
        M_bubble = 1'b1;
        drive(4'h6, 4'h3, 64'h55, 64'h55, 64'h0, 4'h2, 4'h7);
        tick();
        checks++;
        if ({M_icode, M_valE, M_valA, M_dstE, M_dstM} !== {4'h1, 64'h0, 64'h0, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL bubble_m icode=%h valE=%h valA=%h dstE=%h dstM=%h",
                     M_icode, M_valE, M_valA, M_dstE, M_dstM);
        end
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("FAIL bubble_cc zso=%b exp 100", {ZF, SF, OF});
        end
        M_bubble = 1'b0;
        W_stat = 2'd1;
        drive(4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, 4'hF);
        tick();
        checks++;
        if ({ZF, SF, OF, M_icode, M_valE} !== {3'b100, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            failures++;
            $display("FAIL whlt_cc zso=%b icode=%h valE=%h exp 100/6/FFFFFFFFFFFFFFFF",
                     {ZF, SF, OF}, M_icode, M_valE);
        end
        W_stat = 2'd0;
        m_stat = 2'd2;
        drive(4'h6, 4'h0, 64'h5, 64'h0, 64'h0, 4'h2, 4'hF);
        tick();
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("FAIL madr_cc zso=%b exp 100", {ZF, SF, OF});
        end
        m_stat = 2'd0;
    endtask

    task automatic test_mid_reset();
        drive(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, 4'h2, 4'h9);
        tick();
        checks++;
        if ({M_icode, SF} !== {4'h6, 1'b1}) begin
            failures++;
            $display("FAIL pre_rst icode=%h sf=%b exp 6/1", M_icode, SF);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({M_icode, M_dstE, M_dstM, M_valE} !== {4'h1, 4'hF, 4'hF, 64'h0}) begin
            failures++;
            $display("FAIL midrst_m icode=%h dstE=%h dstM=%h valE=%h exp 1/F/F/0",
                     M_icode, M_dstE, M_dstM, M_valE);
        end
        checks++;
        if ({ZF, SF, OF} !== 3'b100) begin
            failures++;
            $display("FAIL midrst_cc zso=%b exp 100", {ZF, SF, OF});
        end
        tick();
        checks++;
        if ({M_icode, ZF, SF} !== {4'h1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_hold icode=%h zf=%b sf=%b exp 1/1/0", M_icode, ZF, SF);
        end
        rst_n = 1'b1;
        drive(4'h6, 4'h0, 64'h2, 64'h3, 64'h0, 4'h2, 4'hF);
        tick();
        checks++;
        if ({M_icode, M_valE, ZF, SF, OF} !== {4'h6, 64'h5, 3'b000}) begin
            failures++;
            $display("FAIL resume icode=%h valE=%h zso=%b exp 6/5/000",
                     M_icode, M_valE, {ZF, SF, OF});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        E_stat   = 2'd0;
        M_bubble = 1'b0;
        m_stat   = 2'd0;
        W_stat   = 2'd0;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        test_reset();
        test_back_to_back();
        test_sub();
        test_add_overflow();
        test_cmov();
        test_push();
        test_bad_ifun();
        test_bubble_cc();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
